// File: rtl/inst_buffer_pkg.sv
// Shared constants and types for the instruction buffer between fetch and decode.
// The issue-mode encodings match the decode stage's issue input.
package inst_buffer_pkg;

    localparam int InstBufDepth  = 16;
    localparam int InstBufPtrBus = 4;

    localparam logic DualIssue   = 1'b1;
    localparam logic SingleIssue = 1'b0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer_ram.sv
// Instruction buffer storage: DEPTH x {inst, pc}.
// It has two synchronous write ports and two asynchronous read ports.
// The top never drives both write ports to the same address in one cycle.
module inst_buffer_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = InstBufDepth,
    parameter int PTR_W = InstBufPtrBus
) (
    input  logic             clk,
    input  logic             i_we_a,
    input  logic [PTR_W-1:0] i_waddr_a,
    input  ib_entry_t        i_wdata_a,
    input  logic             i_we_b,
    input  logic [PTR_W-1:0] i_waddr_b,
    input  ib_entry_t        i_wdata_b,
    input  logic [PTR_W-1:0] i_raddr_a,
    input  logic [PTR_W-1:0] i_raddr_b,
    output ib_entry_t        o_rdata_a,
    output ib_entry_t        o_rdata_b
);

    ib_entry_t r_mem [DEPTH];

    // Write both fetch slots; contents are don't-care out of reset, so there is no reset here.
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
        if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction queue between fetch and decode.
// Fetch pushes 0-2 entries per cycle, and decode pops 0-2 entries per cycle.
// flush_i discards all entries.
// Optional build macro INST_BUFFER_PERF_EN adds two saturating performance counters:
// one counts full cycles and one counts dual-pop cycles.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = InstBufDepth,
    parameter int PTR_W = InstBufPtrBus
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             we1_i,
    input  logic             we2_i,
    input  logic [31:0]      inst1_i,
    input  logic [31:0]      inst2_i,
    input  logic [31:0]      pc1_i,
    input  logic [31:0]      pc2_i,
    input  logic             issue_en_i,
    input  logic             issue_mode_i,
    output logic [31:0]      inst1_o,
    output logic [31:0]      inst2_o,
    output logic [31:0]      pc1_o,
    output logic [31:0]      pc2_o,
    output logic             valid1_o,
    output logic             valid2_o,
    output logic             full_o,
`ifdef INST_BUFFER_PERF_EN
    output logic [31:0]      perf_full_cycles_o,
    output logic [31:0]      perf_dual_issue_o,
`endif
    output logic [PTR_W:0]   count_o
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    ib_entry_t        w_rd1;
    ib_entry_t        w_rd2;

    // Full means fewer than two free slots, so a dual push can never overflow.
    assign w_full = (r_count > (PTR_W+1)'(DEPTH - 2));

    // Push and pop amounts for this cycle.
    // A lone we2_i is illegal and is treated as no push.
    always_comb begin
        w_push = 2'd0;
        if (!w_full && we1_i) w_push = we2_i ? 2'd2 : 2'd1;

        w_pop = 2'd0;
        if (issue_en_i && (r_count != '0)) begin
            if ((issue_mode_i == DualIssue) && (r_count > (PTR_W+1)'(1))) w_pop = 2'd2;
            else                                                       w_pop = 2'd1;
        end
    end

    inst_buffer_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk       (clk),
        .i_we_a    (!flush_i && (w_push != 2'd0)),
        .i_waddr_a (r_tail),
        .i_wdata_a ('{inst: inst1_i, pc: pc1_i}),
        .i_we_b    (!flush_i && (w_push == 2'd2)),
        .i_waddr_b (r_tail + PTR_W'(1)),
        .i_wdata_b ('{inst: inst2_i, pc: pc2_i}),
        .i_raddr_a (r_head),
        .i_raddr_b (r_head + PTR_W'(1)),
        .o_rdata_a (w_rd1),
        .o_rdata_b (w_rd2)
    );

    // Pointer and occupancy update; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    assign valid1_o = (r_count != '0);
    assign valid2_o = (r_count > (PTR_W+1)'(1));
    assign full_o   = w_full;
    assign count_o  = r_count;

    assign inst1_o  = valid1_o ? w_rd1.inst : 32'd0;
    assign pc1_o    = valid1_o ? w_rd1.pc   : 32'd0;
    assign inst2_o  = valid2_o ? w_rd2.inst : 32'd0;
    assign pc2_o    = valid2_o ? w_rd2.pc   : 32'd0;

`ifdef INST_BUFFER_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_dual;

    // Saturating performance counters; only reset clears them, flush does not.
    // A flushed cycle pops nothing, so it does not count as a dual issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_full <= '0;
            r_perf_dual <= '0;
        end else begin
            if (w_full && (r_perf_full != 32'hFFFF_FFFF))
                r_perf_full <= r_perf_full + 32'd1;
            if (!flush_i && (w_pop == 2'd2) && (r_perf_dual != 32'hFFFF_FFFF))
                r_perf_dual <= r_perf_dual + 32'd1;
        end
    end

    assign perf_full_cycles_o = r_perf_full;
    assign perf_dual_issue_o  = r_perf_dual;
`endif

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Dual-issue instruction queue between the fetch/icache stage and the decode stage.
- Accepts 0–2 instructions per cycle from fetch and presents the two oldest to decode as inst1/inst2, with their PCs.
- Pops 0, 1 or 2 entries per cycle, as commanded by the issue controller.
- Provides back-pressure to fetch and a full flush for branch redirects and exceptions.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, ≥ 4.
- PTR_W, 4, log2(DEPTH); width of the head/tail pointers.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush_i  in  1  discard all entries (branch mispredict/redirect, exception)
- we1_i  in  1  fetch slot 1 valid
- we2_i  in  1  fetch slot 2 valid; only legal when we1_i = 1
- inst1_i  in  32  fetch slot 1 instruction
- inst2_i  in  32  fetch slot 2 instruction
- pc1_i  in  32  fetch slot 1 PC
- pc2_i  in  32  fetch slot 2 PC
- issue_en_i  in  1  decode accepts this cycle (not stalled)
- issue_mode_i  in  1  1 = dual issue (pop 2), 0 = single issue (pop 1)
- inst1_o  out  32  head instruction
- inst2_o  out  32  head+1 instruction
- pc1_o  out  32  head PC
- pc2_o  out  32  head+1 PC
- valid1_o  out  1  head entry valid
- valid2_o  out  1  head+1 entry valid
- full_o  out  1  fewer than 2 free entries; fetch must stall
- count_o  out  PTR_W+1  current occupancy

Behaviour:
- Storage: DEPTH × {inst, pc}. Head, tail and count registers; pointers wrap modulo DEPTH.
- Reset (rst = 0, asynchronous):
  - head = tail = count = 0.
  - Storage contents are don't-care.
  - Outputs while empty: valid1_o = valid2_o = 0, full_o = 0, count_o = 0.
  - inst1_o, inst2_o, pc1_o and pc2_o are forced to 0 whenever the corresponding valid is 0.
- Read side (combinational from head):
  - valid1_o = (count ≥ 1); valid2_o = (count ≥ 2).
  - inst2_o/pc2_o read entry (head+1) mod DEPTH.
- Pop count:
  - 0 if issue_en_i = 0.
  - Else min(issue_mode_i ? 2 : 1, count). Dual request with count = 1 pops 1; any request with count = 0 pops 0.
- Push count:
  - we1_i + we2_i, accepted only if full_o = 0 at the start of the cycle; otherwise writes are dropped.
  - Fetch is required to hold while full_o = 1.
  - Slot 1 is written at tail, slot 2 at tail+1 (mod DEPTH).
- Simultaneous push and pop in one cycle:
  - count_next = count + push − pop.
  - head += pop; tail += push.
- full_o = (DEPTH − count < 2), registered-state derived, so it is 0 at DEPTH−2 occupancy and 1 at DEPTH−1 and DEPTH.
- Write-through: none. A pushed instruction becomes visible on the outputs one cycle after its write, so minimum latency fetch→decode is 1 cycle.
- Flush:
  - flush_i = 1 at a clock edge sets head = tail = count = 0.
  - Flush overrides any push and pop in the same cycle; instructions presented on that cycle are discarded.
- we2_i = 1 with we1_i = 0 is illegal; the block treats it as no push.
- Reset asserted mid-operation: state clears immediately and asynchronously; there is no partial push.

Optional Feature:
- Macro: INST_BUFFER_PERF_EN.
- When defined, adds two outputs:
  - perf_full_cycles_o (32 b): counts cycles with full_o = 1.
  - perf_dual_issue_o (32 b): counts cycles popping 2 entries.
- Both counters reset to 0 on rst, saturate at 32'hFFFFFFFF, and are unaffected by flush_i.
- When undefined, the ports and counters do not exist.
- Core behaviour is identical either way.

Decomposition:
- Shared defines file (the team's existing defines include) gains:
  - InstBufDepth, InstBufPtrBus.
  - DualIssue / SingleIssue encodings, reusing the existing issue constants so issue_mode_i matches the decode stage's issue input.
- Natural sub-module: inst_buffer_ram, a DEPTH × 64-bit storage with 2 synchronous write ports and 2 asynchronous read ports. Pointer and count logic stays in inst_buffer.

Test Plan:
- Reset then idle: hold rst = 0 for 3 cycles, release → valid1_o = valid2_o = 0, count_o = 0, full_o = 0, inst1_o = 0.
- Dual push, dual pop:
  - Push {0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004}.
  - Next cycle: valid1_o = valid2_o = 1, inst1_o = 0x24010001, pc2_o = 0xBFC00004.
  - Then issue_en_i = 1, issue_mode_i = 1 → count_o returns to 0.
- Partial pop: count = 1 with issue_mode_i = 1, issue_en_i = 1 → exactly one popped; count_o = 0; no underflow.
- Fill and wrap:
  - Push 2 per cycle with no pops until full_o = 1 (count_o = 16 after 8 cycles; full_o rises at count 15/16).
  - Further writes are ignored.
  - Then pop/push alternately for 40 cycles → in-order sequence with no loss across the pointer wrap.
- Flush priority: count = 6 and flush_i = 1 together with a dual push and a dual pop → next cycle count_o = 0, valid1_o = 0.
- INST_BUFFER_PERF_EN: 10 cycles full plus 5 dual pops → perf_full_cycles_o = 10, perf_dual_issue_o = 5; values persist across a flush.
